// File: rtl/comb_decimator.sv
// CIC comb stage with decimation: every RATE-th input sample is differenced
// against the sample DELAY decimated steps earlier (modulo 2^WIDTH).
module comb_decimator #(
    parameter int WIDTH = 10,
    parameter int RATE  = 4,
    parameter int DELAY = 1
) (
    input  logic             system1000,
    input  logic             system1000_rstn,
    input  logic [WIDTH-1:0] in_i,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] out_o,
    output logic             out_valid
);

    localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [CW-1:0] LAST = CW'(RATE - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hist_q [DELAY];
    logic [WIDTH-1:0] hist_d [DELAY];
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             dec;

    always_comb begin
        dec     = (cnt_q == LAST);
        cnt_d   = dec ? '0 : cnt_q + CW'(1);
        hist_d  = hist_q;
        out_d   = out_q;
        valid_d = 1'b0;
        if (sync_clr) begin
            cnt_d  = '0;
            hist_d = '{default: '0};
            out_d  = '0;
        end else if (dec) begin
            // in_i is only consumed here, so X on other edges never reaches state
            out_d     = in_i - hist_q[DELAY-1];
            hist_d[0] = in_i;
            for (int unsigned i = 1; i < DELAY; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            cnt_q   <= '0;
            hist_q  <= '{default: '0};
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out_o     = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_comb_decimator.sv
// Directed bench: RATE=4/DELAY=1, RATE=4/DELAY=2 and RATE=1/DELAY=1 instances.
module tb_comb_decimator;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [9:0] in_a, in_c;
    logic              clr_a, clr_c;
    logic        [9:0] out_a, out_b, out_c;
    logic              val_a, val_b, val_c;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic signed [9:0] cexp_a [3];
    logic signed [9:0] cexp_b [3];
    logic signed [9:0] r1_in  [4];
    logic signed [9:0] r1_exp [4];

    always #5 clk = ~clk;

    comb_decimator #(.WIDTH(10), .RATE(4), .DELAY(1)) dut_a (
        .system1000(clk), .system1000_rstn(rst_n), .in_i(in_a),
        .sync_clr(clr_a), .out_o(out_a), .out_valid(val_a)
    );

    comb_decimator #(.WIDTH(10), .RATE(4), .DELAY(2)) dut_b (
        .system1000(clk), .system1000_rstn(rst_n), .in_i(in_a),
        .sync_clr(clr_a), .out_o(out_b), .out_valid(val_b)
    );

    comb_decimator #(.WIDTH(10), .RATE(1), .DELAY(1)) dut_c (
        .system1000(clk), .system1000_rstn(rst_n), .in_i(in_c),
        .sync_clr(clr_c), .out_o(out_c), .out_valid(val_c)
    );

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after an edge: pulses reset well clear of the next edge.
    task automatic restart();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Continuation of the ramp after a mid-operation reset or clear at edge 6.
    task automatic post_restart(input string tag);
        for (int k = 7; k <= 14; k++) begin
            in_a = 10'(k);
            tick();
            chk({tag, "_va"}, {9'd0, val_a}, {9'd0, (k == 10 || k == 14)});
            chk({tag, "_vb"}, {9'd0, val_b}, {9'd0, (k == 10 || k == 14)});
            if (k == 10) begin
                chk({tag, "_a10"}, out_a, 10'd10);
                chk({tag, "_b10"}, out_b, 10'd10);
            end
            if (k == 14) begin
                chk({tag, "_a14"}, out_a, 10'd4);
                chk({tag, "_b14"}, out_b, 10'd14);
            end
        end
    endtask

    initial begin
        cexp_a = '{10'sd5, 10'sd0, 10'sd0};
        cexp_b = '{10'sd5, 10'sd5, 10'sd0};
        r1_in  = '{10'sd3, 10'sd7, 10'sd7, -10'sd2};
        r1_exp = '{10'sd3, 10'sd4, 10'sd0, -10'sd9};

        rst_n = 1'b0;
        in_a  = '0;
        in_c  = '0;
        clr_a = 1'b0;
        clr_c = 1'b0;
        #2;
        chk("rst_out_a", out_a, 10'd0);
        chk("rst_val_a", {9'd0, val_a}, 10'd0);
        chk("rst_out_b", out_b, 10'd0);
        chk("rst_out_c", out_c, 10'd0);
        chk("rst_val_c", {9'd0, val_c}, 10'd0);

        // Constant input 5
        in_a = 10'sd5;
        restart();
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("const_va", {9'd0, val_a}, {9'd0, (k % 4 == 0)});
            chk("const_vb", {9'd0, val_b}, {9'd0, (k % 4 == 0)});
            if (k % 4 == 0) begin
                chk("const_a", out_a, cexp_a[k/4-1]);
                chk("const_b", out_b, cexp_b[k/4-1]);
            end
        end

        // Ramp in_i = k at edge k
        restart();
        for (int k = 1; k <= 16; k++) begin
            in_a = 10'(k);
            tick();
            chk("ramp_va", {9'd0, val_a}, {9'd0, (k % 4 == 0)});
            if (k % 4 == 0) begin
                chk("ramp_a", out_a, 10'd4);
                chk("ramp_b", out_b, (k == 4) ? 10'd4 : 10'd8);
            end
        end

        // Wrap-around; X driven on non-decimation edges
        restart();
        for (int k = 1; k <= 8; k++) begin
            if (k == 4)      in_a = 10'sd500;
            else if (k == 8) in_a = -10'sd508;
            else             in_a = 'x;
            tick();
            if (k == 4) begin
                chk("wrap_a4", out_a, 10'd500);
                chk("wrap_b4", out_b, 10'd500);
            end
            if (k == 8) begin
                chk("wrap_a8", out_a, 10'd16);
                chk("wrap_b8", out_b, 10'(-508));
            end
        end
        in_a = '0;

        // Mid-operation asynchronous reset between edges 6 and 7
        restart();
        for (int k = 1; k <= 6; k++) begin
            in_a = 10'(k);
            tick();
        end
        chk("mid_hold_a", out_a, 10'd4);
        chk("mid_hold_va", {9'd0, val_a}, 10'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a", out_a, 10'd0);
        chk("mid_rst_b", out_b, 10'd0);
        chk("mid_rst_va", {9'd0, val_a}, 10'd0);
        #1;
        rst_n = 1'b1;
        post_restart("rst");

        // Same sequence with sync_clr at edge 6
        restart();
        for (int k = 1; k <= 6; k++) begin
            in_a  = 10'(k);
            clr_a = (k == 6);
            tick();
            if (k == 4) begin
                chk("clr_pre_va", {9'd0, val_a}, 10'd1);
                chk("clr_pre_a", out_a, 10'd4);
            end
        end
        clr_a = 1'b0;
        chk("clr_out_a", out_a, 10'd0);
        chk("clr_out_b", out_b, 10'd0);
        chk("clr_va", {9'd0, val_a}, 10'd0);
        post_restart("clr");

        // RATE=1: first difference every cycle
        restart();
        for (int k = 0; k < 4; k++) begin
            in_c = r1_in[k];
            tick();
            chk("r1_valid", {9'd0, val_c}, 10'd1);
            chk("r1_out", out_c, r1_exp[k]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
